mux2_1_arbiter: RTL and testbench
=================================

Name: mux2_1_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between two packet requesters (A, B) and one downstream consumer. It owns the mux SEL line. It grants one requester at a time and holds the grant until end of packet or a burst limit. Data forwards combinationally through the mux; control is registered. It sits between two producers and a single shared output port.

Parameters:
WIDTH, 1, data bits per beat
MAX_BURST, 4, max beats per grant before forced release (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
A_REQ  input  1  A requests access
A_VALID  input  1  A beat valid
A_LAST  input  1  A beat is end of packet
A_DATA  input  WIDTH  A beat data
A_READY  output  1  A beat accepted = GNT_A & OUT_READY
B_REQ, B_VALID, B_LAST, B_DATA, B_READY  same as A, for requester B
OUT_DATA  output  WIDTH  SEL ? B_DATA : A_DATA
OUT_VALID  output  1  granted requester's VALID; 0 when no grant
OUT_LAST  output  1  granted requester's LAST; 0 when no grant
OUT_READY  input  1  consumer accepts beat
SEL  output  1  mux select, registered; 0 = A, 1 = B
GNT_A, GNT_B  output  1  registered one-hot grant; never both 1

Behaviour:
- States: IDLE, GRANT_A, GRANT_B. GNT_A/GNT_B/SEL decode registered state. SEL holds its last value in IDLE.
- Reset (async, any time incl. mid-packet): state IDLE, GNT_A=GNT_B=0, SEL=0, beat counter=0, priority pointer=B (A wins first tie). OUT_VALID=OUT_LAST=0, A_READY=B_READY=0 immediately.
- Transfer = OUT_VALID & OUT_READY. Beat counter increments per transfer and clears on release.
- Release condition in GRANT_x:
  - transfer with x_LAST=1, or
  - transfer with counter==MAX_BURST-1, or
  - x_REQ=0 with counter==0.
- x_REQ dropping mid-packet (counter>0) does not release; the requester must finish the packet.
- Arbitration (IDLE, or on a release cycle): next owner is the requester other than the pointer if it requests, else the pointer requester if it requests, else IDLE. The pointer updates to the granted requester.
  - Back-to-back handover on release: zero bubble cycles.
  - One-cycle latency from REQ in IDLE to GNT.
- Forced release at MAX_BURST: the next packet beat continues under a later grant. The packet is not truncated and OUT_LAST is passed through unmodified.
- MAX_BURST=1: every transfer releases.
- Counter width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1.
- Non-granted READY stays 0 regardless of its VALID.

Decomposition:
- Package mux2_1_pkg holds:
  - state enum (IDLE, GRANT_A, GRANT_B)
  - constants SEL_A=1'b0, SEL_B=1'b1
- Sub-module: datapath built as a generate loop of WIDTH instances of existing mux2_1_dataflow driven by SEL.
- FSM, counter and pointer stay in mux2_1_arbiter.

Test Plan:
- Reset: RST=1 mid-GRANT_B packet -> GNT_A=GNT_B=0, SEL=0, OUT_VALID=0 same cycle. After release, A_REQ=B_REQ=1 -> GNT_A=1 next edge.
- Single requester: A_REQ=1, 3 beats A_DATA=1,0,1, LAST on beat 3, OUT_READY=1 -> OUT_DATA=1,0,1; GNT_A drops the cycle after beat 3; IDLE.
- Round robin: both REQ held, 1-beat packets -> grants alternate A,B,A,B with no idle cycle between grants; SEL toggles 0,1,0,1.
- Burst limit: MAX_BURST=4, A sends 6-beat packet, B_REQ=1 -> A gets 4 beats, B granted next cycle, A resumes beats 5-6 after B's packet.
- Backpressure: OUT_READY=0 for 5 cycles during GRANT_B -> B_READY=0, counter holds, GNT_B holds, OUT_DATA=B_DATA stable.
- Request withdrawal: GRANT_A, A_REQ=0 before any beat -> release next edge; B granted if B_REQ=1, else IDLE. A_REQ=0 after beat 1 -> grant held until LAST.

Source files
------------

// File: rtl/mux2_1_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_1_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_1_arbiter_datapath.sv
// WIDTH-bit shared data path: one single-bit mux per data bit, all on one select.
module mux2_1_arbiter_datapath #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_data_i,
  input  logic [WIDTH-1:0] b_data_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_data_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    mux2_1_dataflow u_mux (
      .a_i   (a_data_i[i]),
      .b_i   (b_data_i[i]),
      .sel_i (sel_i),
      .y_o   (out_data_o[i])
    );
  end

endmodule

// File: rtl/mux2_1_dataflow.sv
// Single-bit 2:1 mux in dataflow form; sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux2_1_dataflow (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = (a_i & ~sel_i) | (b_i & sel_i);

endmodule

// File: rtl/mux2_1_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 packet mux.
// Data flows combinationally; grant, select, beat counter and priority are registered.
module mux2_1_arbiter
  import mux2_1_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_REQ,
  input  logic             A_VALID,
  input  logic             A_LAST,
  input  logic [WIDTH-1:0] A_DATA,
  output logic             A_READY,
  input  logic             B_REQ,
  input  logic             B_VALID,
  input  logic             B_LAST,
  input  logic [WIDTH-1:0] B_DATA,
  output logic             B_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             SEL,
  output logic             GNT_A,
  output logic             GNT_B
);

  localparam int              CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          sel_q, sel_d;

  logic gnt_a, gnt_b, xfer, own_req, release_w, arbitrate, pick_a, pick_b;

  assign gnt_a = (state_q == GRANT_A);
  assign gnt_b = (state_q == GRANT_B);

  assign GNT_A     = gnt_a;
  assign GNT_B     = gnt_b;
  assign SEL       = sel_q;
  assign OUT_VALID = (gnt_a & A_VALID) | (gnt_b & B_VALID);
  assign OUT_LAST  = (gnt_a & A_LAST)  | (gnt_b & B_LAST);
  assign A_READY   = gnt_a & OUT_READY;
  assign B_READY   = gnt_b & OUT_READY;

  mux2_1_arbiter_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a_data_i   (A_DATA),
    .b_data_i   (B_DATA),
    .sel_i      (sel_q),
    .out_data_o (OUT_DATA)
  );

  assign xfer    = OUT_VALID & OUT_READY;
  assign own_req = (gnt_a & A_REQ) | (gnt_b & B_REQ);

  // A requester that drops REQ mid-packet keeps the grant until its packet ends.
  assign release_w = (state_q != IDLE) &
                     ((xfer & (OUT_LAST | (cnt_q == CNT_MAX))) |
                      (~own_req & (cnt_q == '0)));
  assign arbitrate = (state_q == IDLE) | release_w;

  // The requester that did not win last time gets first refusal.
  assign pick_a = A_REQ & ((ptr_q == SEL_B) | ~B_REQ);
  assign pick_b = B_REQ & ((ptr_q == SEL_A) | ~A_REQ);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    if (arbitrate) begin
      cnt_d = '0;
      if (pick_a) begin
        state_d = GRANT_A;
        ptr_d   = SEL_A;
        sel_d   = SEL_A;
      end else if (pick_b) begin
        state_d = GRANT_B;
        ptr_d   = SEL_B;
        sel_d   = SEL_B;
      end else begin
        state_d = IDLE;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= SEL_B;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux2_1_arbiter.sv
// Bench for mux2_1_arbiter: two instances (burst 4 and burst 1) share stimulus and are
// compared every cycle against an integer-level round-robin model, plus directed scenario checks.
module tb_mux2_1_arbiter;

  localparam int W      = 4;
  localparam int BURST0 = 4;
  localparam int BURST1 = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_req = 1'b0, a_valid = 1'b0, a_last = 1'b0;
  logic         b_req = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0;

  logic         d0_a_ready, d0_b_ready, d0_out_valid, d0_out_last, d0_sel, d0_gnt_a, d0_gnt_b;
  logic [W-1:0] d0_out_data;
  logic         d1_a_ready, d1_b_ready, d1_out_valid, d1_out_last, d1_sel, d1_gnt_a, d1_gnt_b;
  logic [W-1:0] d1_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux2_1_arbiter #(.WIDTH(W), .MAX_BURST(BURST0)) dut0 (
    .CLK(clk), .RST(rst),
    .A_REQ(a_req), .A_VALID(a_valid), .A_LAST(a_last), .A_DATA(a_data), .A_READY(d0_a_ready),
    .B_REQ(b_req), .B_VALID(b_valid), .B_LAST(b_last), .B_DATA(b_data), .B_READY(d0_b_ready),
    .OUT_DATA(d0_out_data), .OUT_VALID(d0_out_valid), .OUT_LAST(d0_out_last),
    .OUT_READY(out_ready), .SEL(d0_sel), .GNT_A(d0_gnt_a), .GNT_B(d0_gnt_b)
  );

  mux2_1_arbiter #(.WIDTH(W), .MAX_BURST(BURST1)) dut1 (
    .CLK(clk), .RST(rst),
    .A_REQ(a_req), .A_VALID(a_valid), .A_LAST(a_last), .A_DATA(a_data), .A_READY(d1_a_ready),
    .B_REQ(b_req), .B_VALID(b_valid), .B_LAST(b_last), .B_DATA(b_data), .B_READY(d1_b_ready),
    .OUT_DATA(d1_out_data), .OUT_VALID(d1_out_valid), .OUT_LAST(d1_out_last),
    .OUT_READY(out_ready), .SEL(d1_sel), .GNT_A(d1_gnt_a), .GNT_B(d1_gnt_b)
  );

  // Reference model: owner 0=none 1=A 2=B; beats = transfers in current grant;
  // last_won = owner of the most recent grant (2 after reset so A wins the first tie).
  int m_owner [2];
  int m_beats [2];
  int m_last_won [2];
  int m_sel [2];
  int mv_first, mv_second, mv_pick;
  bit mv_done, mv_fire, mv_req, mv_vld, mv_lst;

  function automatic int burst_of(int k);
    return (k == 0) ? BURST0 : BURST1;
  endfunction

  function automatic bit req_of(int who);
    return (who == 1) ? a_req : b_req;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = 0; m_beats[k] = 0; m_last_won[k] = 2; m_sel[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mv_done = (m_owner[k] == 0);
        if (m_owner[k] != 0) begin
          mv_req  = req_of(m_owner[k]);
          mv_vld  = (m_owner[k] == 1) ? a_valid : b_valid;
          mv_lst  = (m_owner[k] == 1) ? a_last : b_last;
          mv_fire = mv_vld && out_ready;
          mv_done = (mv_fire && (mv_lst || (m_beats[k] + 1 == burst_of(k)))) ||
                    (!mv_req && m_beats[k] == 0);
          if (!mv_done && mv_fire) m_beats[k] = m_beats[k] + 1;
        end
        if (mv_done) begin
          m_beats[k] = 0;
          mv_first   = (m_last_won[k] == 2) ? 1 : 2;
          mv_second  = 3 - mv_first;
          mv_pick    = req_of(mv_first) ? mv_first : (req_of(mv_second) ? mv_second : 0);
          m_owner[k] = mv_pick;
          if (mv_pick != 0) begin
            m_last_won[k] = mv_pick;
            m_sel[k]      = (mv_pick == 2) ? 1 : 0;
          end
        end
      end
    end
  end

  // Output bundle: {gnt_a, gnt_b, sel, out_valid, out_last, a_ready, b_ready, out_data}
  function automatic logic [6+W:0] dut_vec(int k);
    if (k == 0)
      return {d0_gnt_a, d0_gnt_b, d0_sel, d0_out_valid, d0_out_last, d0_a_ready, d0_b_ready, d0_out_data};
    return {d1_gnt_a, d1_gnt_b, d1_sel, d1_out_valid, d1_out_last, d1_a_ready, d1_b_ready, d1_out_data};
  endfunction

  function automatic logic [6+W:0] exp_vec(int k);
    logic ga, gb, s, ov, ol;
    ga = (m_owner[k] == 1);
    gb = (m_owner[k] == 2);
    s  = (m_sel[k] != 0);
    ov = ga ? a_valid : (gb ? b_valid : 1'b0);
    ol = ga ? a_last  : (gb ? b_last  : 1'b0);
    return {ga, gb, s, ov, ol, ga & out_ready, gb & out_ready, s ? b_data : a_data};
  endfunction

  task automatic idle_inputs();
    a_req = 0; a_valid = 0; a_last = 0; a_data = '0;
    b_req = 0; b_valid = 0; b_last = 0; b_data = '0;
    out_ready = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({d0_gnt_a, d0_gnt_b, d0_sel, d0_out_valid, d1_gnt_a, d1_gnt_b, d1_sel, d1_out_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_init got=%b exp=00000000",
               {d0_gnt_a, d0_gnt_b, d0_sel, d0_out_valid, d1_gnt_a, d1_gnt_b, d1_sel, d1_out_valid});
    end
    @(negedge clk);
    rst = 0; b_req = 1; b_valid = 1; b_last = 0; b_data = 4'h3; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset_pre dut%0d got=%b exp=%b", k, dut_vec(k), exp_vec(k));
        end
      end
    end
    // Mid-packet asynchronous reset, well away from any clock edge.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({d0_gnt_a, d0_gnt_b, d0_sel, d0_out_valid, d0_out_last, d0_a_ready, d0_b_ready,
         d1_gnt_a, d1_gnt_b, d1_sel, d1_out_valid, d1_out_last, d1_a_ready, d1_b_ready} !== 14'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=0",
               {d0_gnt_a, d0_gnt_b, d0_sel, d0_out_valid, d0_out_last, d0_a_ready, d0_b_ready,
                d1_gnt_a, d1_gnt_b, d1_sel, d1_out_valid, d1_out_last, d1_a_ready, d1_b_ready});
    end
    @(negedge clk);
    rst = 0; a_req = 1; b_req = 1; b_valid = 0;
    @(negedge clk); #1;
    checks++;
    if ({d0_gnt_a, d0_gnt_b, d1_gnt_a, d1_gnt_b} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_first_tie got=%b exp=1010", {d0_gnt_a, d0_gnt_b, d1_gnt_a, d1_gnt_b});
    end
    a_req = 0; b_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [W-1:0] exp_d;
    @(negedge clk);
    idle_inputs(); a_req = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 1 && i <= 3) begin
        a_valid = 1; a_data = (i == 2) ? 4'h0 : 4'h1; a_last = (i == 3); a_req = (i != 3);
      end else if (i == 4) begin
        a_valid = 0; a_last = 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL single_model dut%0d cyc%0d got=%b exp=%b", k, i, dut_vec(k), exp_vec(k));
        end
      end
      if (i >= 1 && i <= 3) begin
        exp_d = (i == 2) ? 4'h0 : 4'h1;
        checks++;
        if ({d0_gnt_a, d0_out_valid, d0_out_data} !== {2'b11, exp_d}) begin
          errors++;
          $display("FAIL single_beat%0d got=%b exp=%b", i, {d0_gnt_a, d0_out_valid, d0_out_data}, {2'b11, exp_d});
        end
      end else if (i == 4) begin
        checks++;
        if ({d0_gnt_a, d0_gnt_b, d1_gnt_a, d1_gnt_b} !== 4'b0000) begin
          errors++;
          $display("FAIL single_release got=%b exp=0000", {d0_gnt_a, d0_gnt_b, d1_gnt_a, d1_gnt_b});
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_req = 1; b_req = 1; a_valid = 1; b_valid = 1; a_last = 1; b_last = 1;
      a_data = 4'h5; b_data = 4'hA; out_ready = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL rr_model dut%0d cyc%0d got=%b exp=%b", k, i, dut_vec(k), exp_vec(k));
        end
      end
      if (i >= 1) begin
        exp_g = (i % 2 == 1) ? 3'b100 : 3'b011;
        checks++;
        if ({d0_gnt_a, d0_gnt_b, d0_sel} !== exp_g) begin
          errors++;
          $display("FAIL rr_alternate cyc%0d got=%b exp=%b", i, {d0_gnt_a, d0_gnt_b, d0_sel}, exp_g);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  int bl_sel  [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
  int bl_data [8] = '{1, 2, 3, 4, 8, 9, 5, 6};

  task automatic test_burst_limit();
    int a_idx, b_idx;
    int log_q [$];
    int exp_e;
    a_idx = 0; b_idx = 0;
    pulse_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      a_req = (a_idx < 6); a_valid = (a_idx < 6); a_data = W'(a_idx + 1); a_last = (a_idx == 5);
      b_req = (b_idx < 2); b_valid = (b_idx < 2); b_data = W'(b_idx + 8); b_last = (b_idx == 1);
      out_ready = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL burst_model dut%0d cyc%0d got=%b exp=%b", k, c, dut_vec(k), exp_vec(k));
        end
      end
      if (d0_out_valid && out_ready) log_q.push_back(c * 64 + int'(d0_sel) * 16 + int'(d0_out_data));
      if (a_valid && d0_a_ready) a_idx++;
      if (b_valid && d0_b_ready) b_idx++;
    end
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL burst_count got=%0d exp=8", log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_e = (i + 1) * 64 + bl_sel[i] * 16 + bl_data[i];
        checks++;
        if (log_q[i] != exp_e) begin
          errors++;
          $display("FAIL burst_order beat%0d got=cyc%0d sel%0d d%0d exp=cyc%0d sel%0d d%0d", i,
                   log_q[i] / 64, (log_q[i] / 16) % 4, log_q[i] % 16, i + 1, bl_sel[i], bl_data[i]);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_req = (c <= 8); b_valid = (c <= 9); b_data = 4'h9; b_last = 0;
      a_req = (c >= 7 && c <= 9); a_valid = 1; a_data = 4'h6;
      out_ready = (c == 1) || (c >= 7);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL bp_model dut%0d cyc%0d got=%b exp=%b", k, c, dut_vec(k), exp_vec(k));
        end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if ({d0_gnt_b, d0_b_ready, d0_a_ready, d0_out_data} !== {3'b100, 4'h9}) begin
          errors++;
          $display("FAIL bp_stall cyc%0d got=%b exp=%b", c, {d0_gnt_b, d0_b_ready, d0_a_ready, d0_out_data}, {3'b100, 4'h9});
        end
      end else if (c >= 7 && c <= 9) begin
        checks++;
        if ({d0_gnt_a, d0_gnt_b, d0_b_ready} !== 3'b011) begin
          errors++;
          $display("FAIL bp_hold cyc%0d got=%b exp=011", c, {d0_gnt_a, d0_gnt_b, d0_b_ready});
        end
      end else if (c == 10) begin
        checks++;
        if ({d0_gnt_a, d0_gnt_b, d0_sel} !== 3'b100) begin
          errors++;
          $display("FAIL bp_forced_release got=%b exp=100", {d0_gnt_a, d0_gnt_b, d0_sel});
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_withdrawal();
    logic [1:0] exp_g [9];
    exp_g = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    pulse_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      a_req   = (c == 0) || (c == 3) || (c == 4);
      b_req   = (c == 1);
      b_valid = 0;
      a_valid = (c == 4) || (c == 7);
      a_last  = (c == 7);
      a_data  = 4'h7;
      out_ready = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL wd_model dut%0d cyc%0d got=%b exp=%b", k, c, dut_vec(k), exp_vec(k));
        end
      end
      checks++;
      if ({d0_gnt_a, d0_gnt_b} !== exp_g[c]) begin
        errors++;
        $display("FAIL wd_grant cyc%0d got=%b exp=%b", c, {d0_gnt_a, d0_gnt_b}, exp_g[c]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      a_req     = ($urandom_range(9) < 7);
      b_req     = ($urandom_range(9) < 7);
      a_valid   = ($urandom_range(9) < 7);
      b_valid   = ($urandom_range(9) < 7);
      a_last    = ($urandom_range(9) < 3);
      b_last    = ($urandom_range(9) < 3);
      a_data    = W'($urandom);
      b_data    = W'($urandom);
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(99) == 0) rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL rand_model dut%0d cyc%0d got=%b exp=%b", k, c, dut_vec(k), exp_vec(k));
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_withdrawal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
